// File: rtl/spi_deserializer_if.sv
`default_nettype none
// ============================================================================
//  Module      : spi_deserializer_if
//  Description : Bundles the SPI receive pins (sclk, mosi), the receive-FIFO
//                write port (full, write_data, write_en) and the status
//                pulses (done, overrun, frame_err, busy) of spi_deserializer.
//                slave  : deserializer side (consumes pins, drives FIFO/status)
//                master : environment side (drives pins and full)
//  Revision    : 1.0  initial release
// ============================================================================
interface spi_deserializer_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  sclk;
  logic                  mosi;
  logic                  full;
  logic [DATA_WIDTH-1:0] write_data;
  logic                  write_en;
  logic                  done;
  logic                  overrun;
  logic                  frame_err;
  logic                  busy;

  modport slave (
    input  sclk, mosi, full,
    output write_data, write_en, done, overrun, frame_err, busy
  );

  modport master (
    output sclk, mosi, full,
    input  write_data, write_en, done, overrun, frame_err, busy
  );
endinterface
`default_nettype wire

// File: rtl/spi_deserializer.sv
`default_nettype none
// ============================================================================
//  Module      : spi_deserializer
//  Description : SPI receive end. Synchronises sclk/mosi into clk, samples
//                mosi on each rising sclk (MSB first), assembles DATA_WIDTH
//                bit words and writes each one to a receive FIFO with a
//                one-cycle strobe. Reports overrun (FIFO full at store time)
//                and framing errors (mid-frame timeout, stray sclk edge).
//  Ports       : clk        system clock, posedge
//                rst        asynchronous reset, active low
//                bus.sclk   SPI clock, idle low, asynchronous to clk
//                bus.mosi   SPI data, stable around rising sclk
//                bus.full   receive FIFO full
//                bus.write_data / bus.write_en  FIFO write port
//                bus.done / overrun / frame_err one-cycle status pulses
//                bus.busy   high whenever the FSM is not idle
//  Revision    : 1.0  initial release
// ============================================================================
module spi_deserializer #(
  parameter int DATA_WIDTH     = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                clk,
  input  logic                rst,
  spi_deserializer_if.slave   bus
);

  localparam int CNT_W  = $clog2(DATA_WIDTH) + 1;
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES) + 1;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_SHIFT    = 2'd1;
  localparam logic [1:0] ST_STORE    = 2'd2;
  localparam logic [1:0] ST_COMPLETE = 2'd3;

  localparam logic [CNT_W-1:0]  C_BITS_FULL = CNT_W'(DATA_WIDTH);
  localparam logic [CNT_W-1:0]  C_BITS_REST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [IDLE_W-1:0] C_TIMEOUT   = IDLE_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]             state_q, state_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic [DATA_WIDTH-1:0]  shift_reg_q, shift_reg_d;
  logic [CNT_W-1:0]       bit_counter_q, bit_counter_d;
  logic [IDLE_W-1:0]      idle_cnt_q, idle_cnt_d;
  logic [DATA_WIDTH-1:0]  write_data_q, write_data_d;
  logic                   write_en_q, write_en_d;
  logic                   done_q, done_d;
  logic                   overrun_q, overrun_d;
  logic                   frame_err_q, frame_err_d;
  logic                   busy_q, busy_d;

  logic sclk_s;
  logic mosi_s;
  logic rise;
  logic timeout;

  // Both synchronisers have the same depth so mosi_s is the value that was
  // on the pin when the synced rising edge was captured.
  assign sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk};
  assign mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi};
  assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_prev_d = sclk_s;
  assign rise        = sclk_s & ~sclk_prev_q;
  assign timeout     = (idle_cnt_q == C_TIMEOUT);

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      sclk_sync_q   <= '0;
      mosi_sync_q   <= '0;
      sclk_prev_q   <= 1'b0;
      shift_reg_q   <= '0;
      bit_counter_q <= C_BITS_FULL;
      idle_cnt_q    <= '0;
      write_data_q  <= '0;
      write_en_q    <= 1'b0;
      done_q        <= 1'b0;
      overrun_q     <= 1'b0;
      frame_err_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      sclk_sync_q   <= sclk_sync_d;
      mosi_sync_q   <= mosi_sync_d;
      sclk_prev_q   <= sclk_prev_d;
      shift_reg_q   <= shift_reg_d;
      bit_counter_q <= bit_counter_d;
      idle_cnt_q    <= idle_cnt_d;
      write_data_q  <= write_data_d;
      write_en_q    <= write_en_d;
      done_q        <= done_d;
      overrun_q     <= overrun_d;
      frame_err_q   <= frame_err_d;
      busy_q        <= busy_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (rise) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        // Counter at 1 means this rise delivers the last bit of the word.
        if (rise) begin
          if (bit_counter_q == CNT_W'(1)) state_d = ST_STORE;
        end else if (timeout) begin
          state_d = ST_IDLE;
        end
      end
      ST_STORE:    state_d = ST_COMPLETE;
      ST_COMPLETE: state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath and output logic (all outputs registered)
  // --------------------------------------------------------------------------
  always_comb begin
    shift_reg_d   = shift_reg_q;
    bit_counter_d = bit_counter_q;
    idle_cnt_d    = idle_cnt_q;
    write_data_d  = write_data_q;
    write_en_d    = 1'b0;
    done_d        = 1'b0;
    overrun_d     = 1'b0;
    frame_err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        idle_cnt_d = '0;
        if (rise) begin
          shift_reg_d   = {shift_reg_q[DATA_WIDTH-2:0], mosi_s};
          bit_counter_d = C_BITS_REST;
        end
      end
      ST_SHIFT: begin
        if (rise) begin
          shift_reg_d   = {shift_reg_q[DATA_WIDTH-2:0], mosi_s};
          bit_counter_d = bit_counter_q - CNT_W'(1);
          idle_cnt_d    = '0;
        end else if (timeout) begin
          // Abandon the partial word; the frame never reports done.
          frame_err_d   = 1'b1;
          shift_reg_d   = '0;
          bit_counter_d = C_BITS_FULL;
          idle_cnt_d    = '0;
        end else begin
          idle_cnt_d = idle_cnt_q + IDLE_W'(1);
        end
      end
      ST_STORE: begin
        // full is only consulted here; the word is either written or dropped.
        if (bus.full) begin
          overrun_d = 1'b1;
        end else begin
          write_en_d   = 1'b1;
          write_data_d = shift_reg_q;
        end
        // A rise here belongs to no word; flag it but keep sequencing.
        if (rise) frame_err_d = 1'b1;
      end
      ST_COMPLETE: begin
        done_d        = 1'b1;
        bit_counter_d = C_BITS_FULL;
        if (rise) frame_err_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy_d = (state_d != ST_IDLE);

  assign bus.write_data = write_data_q;
  assign bus.write_en   = write_en_q;
  assign bus.done       = done_q;
  assign bus.overrun    = overrun_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.busy       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_deserializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_deserializer
//  Description : Self-checking bench for spi_deserializer. Frames are driven
//                MSB first with mosi changing while sclk is low; every word
//                expected at the FIFO is queued when its frame is driven and
//                popped when write_en is seen.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_spi_deserializer;

  localparam int DW = 8;

  logic clk;
  logic rst;

  spi_deserializer_if #(.DATA_WIDTH(DW)) bus ();

  spi_deserializer #(
    .DATA_WIDTH    (DW),
    .SYNC_STAGES   (2),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] exp_q[$];
  int n_wr   = 0;
  int n_done = 0;
  int n_ovr  = 0;
  int n_ferr = 0;
  int cycle  = 0;
  int last_wr_cycle   = -1;
  int last_done_cycle = -1;
  logic prev_we, prev_done, prev_ovr, prev_ferr;

  // Scoreboard monitor: samples outputs on the falling edge.
  initial begin
    prev_we = 0; prev_done = 0; prev_ovr = 0; prev_ferr = 0;
  end

  always @(negedge clk) begin
    cycle++;
    if (bus.write_en === 1'b1) begin
      n_wr++;
      last_wr_cycle = cycle;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got write_data=%h, expected no write", bus.write_data);
      end else begin
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        if (bus.write_data !== e) begin
          errors++;
          $display("FAIL write_data: got %h, expected %h", bus.write_data, e);
        end
      end
    end
    if (bus.done === 1'b1) begin
      n_done++;
      last_done_cycle = cycle;
    end
    if (bus.overrun === 1'b1) n_ovr++;
    if (bus.frame_err === 1'b1) n_ferr++;
    if (bus.write_en === 1'b1 || bus.done === 1'b1 || bus.overrun === 1'b1) begin
      checks++;
      if ((bus.write_en & bus.overrun) !== 1'b0 || (bus.write_en & bus.done) !== 1'b0 ||
          (prev_we & bus.write_en) !== 1'b0 || (prev_done & bus.done) !== 1'b0 ||
          (prev_ovr & bus.overrun) !== 1'b0) begin
        errors++;
        $display("FAIL pulse_rules: got we=%b done=%b ovr=%b (prev we=%b done=%b ovr=%b), expected single exclusive pulses",
                 bus.write_en, bus.done, bus.overrun, prev_we, prev_done, prev_ovr);
      end
    end
    prev_we   = bus.write_en;
    prev_done = bus.done;
    prev_ovr  = bus.overrun;
    prev_ferr = bus.frame_err;
  end

  // Drives the top nbits of value, MSB first; half period of `half` clocks.
  task automatic send_bits(input logic [DW-1:0] value, input int nbits, input int half);
    for (int i = DW - 1; i >= DW - nbits; i--) begin
      @(negedge clk);
      bus.mosi = value[i];
      repeat (half) @(negedge clk);
      bus.sclk = 1'b1;
      repeat (half) @(negedge clk);
      bus.sclk = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [DW-1:0] value);
    if (bus.full == 1'b0) exp_q.push_back(value);
    send_bits(value, DW, 2);
  endtask

  task automatic test_reset();
    bus.sclk = 0; bus.mosi = 0; bus.full = 0;
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.sclk = ~bus.sclk;
      bus.mosi = ~bus.mosi;
      checks++;
      if ({bus.write_en, bus.done, bus.overrun, bus.frame_err, bus.busy} !== 5'b0 ||
          bus.write_data !== '0) begin
        errors++;
        $display("FAIL reset_outputs: got we=%b done=%b ovr=%b ferr=%b busy=%b data=%h, expected all 0",
                 bus.write_en, bus.done, bus.overrun, bus.frame_err, bus.busy, bus.write_data);
      end
    end
    bus.sclk = 0; bus.mosi = 0;
    repeat (4) @(negedge clk);
    rst = 1;
    repeat (4) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || n_wr != 0) begin
      errors++;
      $display("FAIL reset_release: got busy=%b writes=%0d, expected busy=0 writes=0", bus.busy, n_wr);
    end
  endtask

  task automatic test_basic();
    int w0, d0;
    w0 = n_wr; d0 = n_done;
    bus.full = 0;
    send_frame(8'hA5);
    repeat (12) @(negedge clk);
    checks++;
    if (n_wr - w0 != 1 || n_done - d0 != 1) begin
      errors++;
      $display("FAIL basic_counts: got writes=%0d done=%0d, expected 1 and 1", n_wr - w0, n_done - d0);
    end
    checks++;
    if (last_done_cycle != last_wr_cycle + 1) begin
      errors++;
      $display("FAIL basic_done_timing: got done cycle %0d, expected %0d", last_done_cycle, last_wr_cycle + 1);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_idle: got busy=%b, expected 0", bus.busy);
    end
  endtask

  task automatic test_overrun();
    int w0, d0, o0;
    w0 = n_wr; d0 = n_done; o0 = n_ovr;
    bus.full = 1;
    send_frame(8'h3C);
    repeat (12) @(negedge clk);
    bus.full = 0;
    checks++;
    if (n_wr != w0 || n_ovr - o0 != 1 || n_done - d0 != 1) begin
      errors++;
      $display("FAIL overrun_counts: got writes=%0d ovr=%0d done=%0d, expected 0 1 1",
               n_wr - w0, n_ovr - o0, n_done - d0);
    end
  endtask

  task automatic test_timeout();
    int w0, d0, f0;
    w0 = n_wr; d0 = n_done; f0 = n_ferr;
    send_bits(8'hE0, 3, 2);
    repeat (40) @(negedge clk);
    checks++;
    if (n_ferr != f0 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL timeout_early: got ferr=%0d busy=%b, expected 0 and 1", n_ferr - f0, bus.busy);
    end
    repeat (40) @(negedge clk);
    checks++;
    if (n_ferr - f0 != 1 || bus.busy !== 1'b0 || n_wr != w0 || n_done != d0) begin
      errors++;
      $display("FAIL timeout_abort: got ferr=%0d busy=%b writes=%0d done=%0d, expected 1 0 0 0",
               n_ferr - f0, bus.busy, n_wr - w0, n_done - d0);
    end
    send_frame(8'h81);
    repeat (12) @(negedge clk);
    checks++;
    if (n_wr - w0 != 1 || n_ferr - f0 != 1) begin
      errors++;
      $display("FAIL timeout_recover: got writes=%0d ferr=%0d, expected 1 and 1", n_wr - w0, n_ferr - f0);
    end
  endtask

  task automatic test_reset_mid();
    int w0;
    w0 = n_wr;
    send_bits(8'h5A, 5, 2);
    @(negedge clk);
    rst = 0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_busy: got busy=%b, expected 0", bus.busy);
    end
    rst = 1;
    repeat (3) @(negedge clk);
    send_frame(8'hFF);
    repeat (12) @(negedge clk);
    checks++;
    if (n_wr - w0 != 1) begin
      errors++;
      $display("FAIL reset_mid_writes: got %0d writes, expected 1", n_wr - w0);
    end
  endtask

  task automatic test_back_to_back();
    int w0, d0;
    w0 = n_wr; d0 = n_done;
    send_frame(8'h00);
    repeat (4) @(negedge clk);
    send_frame(8'hFF);
    repeat (12) @(negedge clk);
    checks++;
    if (n_wr - w0 != 2 || n_done - d0 != 2) begin
      errors++;
      $display("FAIL b2b_counts: got writes=%0d done=%0d, expected 2 and 2", n_wr - w0, n_done - d0);
    end
  endtask

  task automatic test_drain();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d words outstanding, expected 0", exp_q.size());
    end
    checks++;
    if (n_ferr != 1) begin
      errors++;
      $display("FAIL total_frame_err: got %0d, expected 1", n_ferr);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overrun();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
